// File: rtl/aritmetica_mac_seq_pkg.sv
// ---------------------------------------------------------------------------
// aritmetica_pkg
// Shared definitions for the sequential multiply-accumulate stage:
//   - state_t : controller state encoding (IDLE / MAC / DONE)
//   - clog2   : ceiling log2 usable in parameter expressions
//   - acc_w   : accumulator width that can never overflow for TAPS products
// ---------------------------------------------------------------------------
package aritmetica_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Each product needs 2N bits; summing TAPS of them plus the sign-extended
  // addend needs clog2(TAPS) growth bits plus one more for the addend.
  function automatic int acc_w(input int n, input int taps);
    return 2 * n + clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/aritmetica_mac_seq_if.sv
// ---------------------------------------------------------------------------
// aritmetica_mac_seq_if
// Operand / result handshake bundle of the MAC stage.
//   in_valid / in_ready      : operand-set handshake
//   Constantes_G, Multip_G   : flat TAPS*N vectors, tap i at [i*N +: N]
//   Entrada_G                : signed addend
//   out_valid / out_ready    : result handshake
//   Valores, out_q, ovf      : full-precision sum, rescaled Q result, overflow
// Modports: master = producer/consumer side, slave = the MAC block.
// ---------------------------------------------------------------------------
interface aritmetica_mac_seq_if
  import aritmetica_pkg::*;
#(
  parameter int N    = 25,
  parameter int TAPS = 3
);
  localparam int ACC_W = acc_w(N, TAPS);

  logic                in_valid;
  logic                in_ready;
  logic [TAPS*N-1:0]   Constantes_G;
  logic [TAPS*N-1:0]   Multip_G;
  logic [N-1:0]        Entrada_G;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    Valores;
  logic [N-1:0]        out_q;
  logic                ovf;

  modport master (
    output in_valid, Constantes_G, Multip_G, Entrada_G, out_ready,
    input  in_ready, out_valid, Valores, out_q, ovf
  );

  modport slave (
    input  in_valid, Constantes_G, Multip_G, Entrada_G, out_ready,
    output in_ready, out_valid, Valores, out_q, ovf
  );

endinterface

// File: rtl/aritmetica_mac_seq_saturador_q.sv
// ---------------------------------------------------------------------------
// saturador_q
// Combinational rescaler: takes the full-precision accumulator, shifts it
// right arithmetically by FRAC (rounding toward -inf) and fits it to N bits.
//   i_acc : signed ACC_W accumulator value
//   o_q   : N-bit rescaled result
//   o_ovf : shifted value does not fit in signed N bits
// Build option ARIT_SAT_EN: when defined, o_q saturates on overflow;
// otherwise o_q is the wrapped low N bits (o_ovf is reported either way).
// ---------------------------------------------------------------------------
module saturador_q #(
  parameter int N     = 25,
  parameter int FRAC  = 10,
  parameter int ACC_W = 53
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic        [N-1:0]     o_q,
  output logic                    o_ovf
);

  logic signed [ACC_W-1:0] w_sh;
  logic        [ACC_W-N:0] w_hi;

  assign w_sh = i_acc >>> FRAC;

  // The value fits in signed N bits iff every bit from the N-bit sign
  // position upward is a copy of the sign.
  assign w_hi  = w_sh[ACC_W-1:N-1];
  assign o_ovf = ~((&w_hi) | ~(|w_hi));

`ifdef ARIT_SAT_EN
  assign o_q = !o_ovf         ? w_sh[N-1:0] :
               w_sh[ACC_W-1]  ? {1'b1, {(N-1){1'b0}}} :
                                {1'b0, {(N-1){1'b1}}};
`else
  assign o_q = w_sh[N-1:0];
`endif

endmodule

// File: rtl/aritmetica_mac_seq.sv
// ---------------------------------------------------------------------------
// aritmetica_mac_seq
// Sequential MAC: Valores = sext(Entrada_G) + sum_i Constantes_G[i]*Multip_G[i]
// using one shared multiplier over TAPS cycles, with valid/ready on both
// sides and a rescaled Q-format result (out_q) plus overflow flag (ovf).
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : aritmetica_mac_seq_if.slave (operands in, results out)
// Build option ARIT_SAT_EN selects saturating out_q (see saturador_q).
// ---------------------------------------------------------------------------
module aritmetica_mac_seq
  import aritmetica_pkg::*;
#(
  parameter int N    = 25,
  parameter int TAPS = 3,
  parameter int FRAC = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  aritmetica_mac_seq_if.slave  bus
);

  localparam int ACC_W = acc_w(N, TAPS);
  localparam int IDX_W = clog2(TAPS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t                  r_state;
  logic [TAPS*N-1:0]       r_c;
  logic [TAPS*N-1:0]       r_m;
  logic [IDX_W-1:0]        r_idx;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_valores;
  logic [N-1:0]            r_out_q;
  logic                    r_ovf;
  logic                    r_in_ready;
  logic                    r_out_valid;

  logic signed [N-1:0]     w_c;
  logic signed [N-1:0]     w_m;
  logic signed [2*N-1:0]   w_c_x;
  logic signed [2*N-1:0]   w_m_x;
  logic signed [2*N-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [N-1:0]            w_q;
  logic                    w_ovf;

  // Shared multiplier on the current tap. Operands are widened to 2N first so
  // the exact signed product is the low 2N bits of the multiply.
  assign w_c        = r_c[r_idx*N +: N];
  assign w_m        = r_m[r_idx*N +: N];
  assign w_c_x      = {{N{w_c[N-1]}}, w_c};
  assign w_m_x      = {{N{w_m[N-1]}}, w_m};
  assign w_prod     = w_c_x * w_m_x;
  assign w_acc_next = r_acc + {{(ACC_W-2*N){w_prod[2*N-1]}}, w_prod};

  // Rescaling sees the final sum directly so the outputs can be registered
  // on the same edge that adds the last tap.
  saturador_q #(
    .N     (N),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_saturador_q (
    .i_acc (w_acc_next),
    .o_q   (w_q),
    .o_ovf (w_ovf)
  );

  // NOTE: all state is assigned with non-blocking (<=) so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_c         <= '0;
      r_m         <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_valores   <= '0;
      r_out_q     <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_c        <= bus.Constantes_G;
            r_m        <= bus.Multip_G;
            r_acc      <= {{(ACC_W-N){bus.Entrada_G[N-1]}}, bus.Entrada_G};
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_valores   <= w_acc_next;
            r_out_q     <= w_q;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            // ovf is meaningful only alongside out_valid; Valores/out_q
            // simply hold their last value.
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Valores   = r_valores;
  assign bus.out_q     = r_out_q;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_aritmetica_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_aritmetica_mac_seq
// Self-checking bench for aritmetica_mac_seq (N=25, TAPS=3, FRAC=10).
// A scoreboard computes each expected result with plain 64-bit arithmetic
// when an operand set is accepted; a negedge process compares every cycle
// out_valid is high. Directed tests add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_aritmetica_mac_seq;
  import aritmetica_pkg::*;

  localparam int N     = 25;
  localparam int TAPS  = 3;
  localparam int FRAC  = 10;
  localparam int ACC_W = acc_w(N, TAPS);

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  aritmetica_mac_seq_if #(.N(N), .TAPS(TAPS)) bus ();

  aritmetica_mac_seq #(.N(N), .TAPS(TAPS), .FRAC(FRAC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    longint val;
    longint q;
    bit     ovf;
  } exp_t;

  exp_t   sb[$];
  longint rises[$];
  longint cyc     = 0;
  bit     prev_ov = 1'b0;
  int     n_pass  = 0;
  int     n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: exact sum, floor shift, range test, then wrap or saturate.
  function automatic exp_t model(input logic [N-1:0] e,
                                 input logic [TAPS*N-1:0] c,
                                 input logic [TAPS*N-1:0] m);
    exp_t   r;
    longint s, sh, lim;
    s = longint'($signed(e));
    for (int i = 0; i < TAPS; i++)
      s += longint'($signed(c[i*N +: N])) * longint'($signed(m[i*N +: N]));
    sh    = s >>> FRAC;
    lim   = longint'(1) <<< (N - 1);
    r.val = s;
    r.ovf = (sh >= lim) || (sh < -lim);
`ifdef ARIT_SAT_EN
    if (!r.ovf)      r.q = sh;
    else if (sh < 0) r.q = -lim;
    else             r.q = lim - 1;
`else
    r.q = (sh <<< (64 - N)) >>> (64 - N);
`endif
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on an accepting edge, pop on a consuming edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.Entrada_G, bus.Constantes_G, bus.Multip_G));
    end
  end

  // Compare process.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.out_valid) begin
        if (!prev_ov) rises.push_back(cyc);
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          check("sb_valores", longint'($signed(bus.Valores)), sb[0].val);
          check("sb_out_q",   longint'($signed(bus.out_q)),   sb[0].q);
          check("sb_ovf",     longint'(bus.ovf),              longint'(sb[0].ovf));
          check("sb_in_ready_busy", longint'(bus.in_ready), 0);
        end
      end else begin
        check("ovf_idle", longint'(bus.ovf), 0);
      end
      prev_ov <= bus.out_valid;
    end
  end

  // Present an operand set at a negedge and return at the negedge after the
  // accepting edge; in_valid is left high for the caller to decide.
  task automatic send(input logic signed [N-1:0] e,
                      input logic signed [N-1:0] c0, input logic signed [N-1:0] m0,
                      input logic signed [N-1:0] c1, input logic signed [N-1:0] m1,
                      input logic signed [N-1:0] c2, input logic signed [N-1:0] m2);
    int k;
    bus.Entrada_G    = e;
    bus.Constantes_G = {c2, c1, c0};
    bus.Multip_G     = {m2, m1, m0};
    bus.in_valid     = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Count edges (from the negedge after acceptance) until out_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  longint'(bus.in_ready),  1);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_valores"},   longint'($signed(bus.Valores)), 0);
    check({tag, "_out_q"},     longint'($signed(bus.out_q)),   0);
    check({tag, "_ovf"},       longint'(bus.ovf), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     lat;
    int     r0;
    longint hold_v, hold_q;

    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b1;
    bus.Entrada_G    = '0;
    bus.Constantes_G = '0;
    bus.Multip_G     = '0;

    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic: 5 + 6 - 20 + 1 = -8; -8 >>> 10 = -1.
    send(5, 2, 3, -4, 5, 1, 1);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("basic_latency", lat, TAPS);
    check("basic_valores", longint'($signed(bus.Valores)), -8);
    check("basic_out_q",   longint'($signed(bus.out_q)),   -1);
    check("basic_ovf",     longint'(bus.ovf), 0);
    @(negedge clk);
    check("basic_release_valid", longint'(bus.out_valid), 0);
    check("basic_release_ready", longint'(bus.in_ready),  1);

    // Max positive: 3*(2^24-1)^2; shifted = 824633622528.
    send(0, 16777215, 16777215, 16777215, 16777215, 16777215, 16777215);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("maxpos_valores", longint'($signed(bus.Valores)), 64'sd844424829468675);
    check("maxpos_ovf",     longint'(bus.ovf), 1);
`ifdef ARIT_SAT_EN
    check("maxpos_out_q",   longint'($signed(bus.out_q)), 16777215);
`else
    check("maxpos_out_q",   longint'($signed(bus.out_q)), -98304);
`endif
    @(negedge clk);

    // Most negative: 3*2^48 - 2^24; shifted = 3*2^38 - 2^14.
    send(-16777216, -16777216, -16777216, -16777216, -16777216, -16777216, -16777216);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("maxneg_valores", longint'($signed(bus.Valores)), 64'sd844424913354752);
    check("maxneg_ovf",     longint'(bus.ovf), 1);
`ifdef ARIT_SAT_EN
    check("maxneg_out_q",   longint'($signed(bus.out_q)), 16777215);
`else
    check("maxneg_out_q",   longint'($signed(bus.out_q)), -16384);
`endif
    @(negedge clk);

    // Backpressure: 100 - 21 + 143 - 18 = 204.
    bus.out_ready = 1'b0;
    send(100, 7, -3, 11, 13, -9, 2);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp_valores", longint'($signed(bus.Valores)), 204);
    hold_v = longint'($signed(bus.Valores));
    hold_q = longint'($signed(bus.out_q));
    send_noise: begin
      bus.Entrada_G    = 25'sd77;
      bus.Constantes_G = {25'sd9, 25'sd9, 25'sd9};
      bus.in_valid     = 1'b1;
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valores", longint'($signed(bus.Valores)), hold_v);
      check("bp_hold_out_q",   longint'($signed(bus.out_q)),   hold_q);
      check("bp_hold_valid",   longint'(bus.out_valid), 1);
      check("bp_hold_ready",   longint'(bus.in_ready),  0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", longint'(bus.out_valid), 0);
    check("bp_release_ready", longint'(bus.in_ready),  1);

    // Reset during the idx=1 MAC cycle.
    send(1, 1, 1, 1, 1, 1, 1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midreset_ready_after", longint'(bus.in_ready),  1);
    check("midreset_no_result",   longint'(bus.out_valid), 0);
    // -3 + 1000000 - 6000 - 35 = 993962; >>> 10 = 970.
    send(-3, 1000, 1000, -2000, 3, 5, -7);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("postreset_valores", longint'($signed(bus.Valores)), 993962);
    check("postreset_out_q",   longint'($signed(bus.out_q)),   970);
    @(negedge clk);

    // Back-to-back with in_valid and out_ready held high.
    r0 = rises.size();
    send(1, 2, 3, 4, 5, 6, 7);
    send(-1, -2, 3, 4, -5, 6, 7);
    send(1023, 1024, 1024, 0, 0, -1, 1);
    send(-1024, 4095, -4095, 12, 12, 3, 3);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (rises.size() >= r0 + 4 && !bus.out_valid) break;
      @(negedge clk);
    end
    check("b2b_count", longint'(rises.size() - r0), 4);
    if (rises.size() >= r0 + 4) begin
      for (int i = 1; i < 4; i++)
        check("b2b_spacing", rises[r0+i] - rises[r0+i-1], TAPS + 2);
    end
    check("b2b_drained", longint'(sb.size()), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
